// File: rtl/cordic_pkg.sv
// Shared widths, Q4.20 constants and pipeline payload types for the CORDIC angle front end.
package cordic_pkg;

  localparam int unsigned FLOAT_DATA_WIDTH  = 32;
  localparam int unsigned INTEGER_WIDTH     = 4;
  localparam int unsigned FRACTIONAL_WIDTH  = 20;
  localparam int unsigned CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int unsigned COUNTER_WIDTH     = 10;
  localparam int unsigned EXP_WIDTH         = 8;
  localparam int unsigned MANT_WIDTH        = 24;
  localparam int unsigned MAG_WIDTH         = MANT_WIDTH + 1;
  localparam int unsigned EXP_BIAS          = 127;
  // Exponent at which |v| >= 2^(INTEGER_WIDTH-1) no longer fits the signed integer field.
  localparam int unsigned EXP_SAT           = EXP_BIAS + INTEGER_WIDTH - 1;

  typedef logic signed [CORDIC_DATA_WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 24'h7FFFFF;
  localparam fixed_t FIXED_MIN = 24'h800000;

  typedef struct packed {
    logic                  valid;
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic                  frac_nz;
    logic [MANT_WIDTH-1:0] mant;
  } unpack_t;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic                 sat;
    logic [MAG_WIDTH-1:0] mag;
  } shift_t;

endpackage

// File: rtl/delay_counter.sv
// Free-running delay counter: counts up to max after a clear; done while count >= max.
module delay_counter
  import cordic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [COUNTER_WIDTH-1:0] max,
  output logic                     done
);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count < max) begin
      count <= count + COUNTER_WIDTH'(1);
    end
  end

  assign done = (count >= max);

endmodule

// File: rtl/fp_fixed_convert_cmp.sv
// IEEE-754 single to signed Q4.20 angle converter (3 stages), signed comparator, delay counter.
// Build option ROUND_NEAREST_EN: stage 2 rounds to nearest-even instead of truncating.
module fp_fixed_convert_cmp
  import cordic_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [FLOAT_DATA_WIDTH-1:0] angle_float,
  output fixed_t                      angle,
  output logic                        angle_valid,
  input  fixed_t                      working_angle,
  output logic                        agb,
  output logic                        aeb,
  input  logic [COUNTER_WIDTH-1:0]    counter_max,
  input  logic                        delay_clr,
  output logic                        counter_done
);

  localparam int unsigned SHAMT_WIDTH = 6;
  localparam int unsigned MAX_SHIFT   = 2 * MANT_WIDTH - 1;

  unpack_t                 s1_d, s1_q;
  shift_t                  s2_d, s2_q;
  fixed_t                  angle_d;
  logic [EXP_WIDTH-1:0]    sh_diff;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [MANT_WIDTH-1:0]   mag_trunc;
`ifdef ROUND_NEAREST_EN
  logic [MANT_WIDTH-1:0]   rem;
  logic                    round_up;
`endif

  // Stage 1: unpack sign, exponent and mantissa with hidden one.
  always_comb begin
    s1_d         = '0;
    s1_d.valid   = 1'b1;
    s1_d.sign    = angle_float[FLOAT_DATA_WIDTH-1];
    s1_d.exp     = angle_float[30:23];
    s1_d.frac_nz = |angle_float[22:0];
    s1_d.mant    = {1'b1, angle_float[22:0]};
  end

  // Stage 2: classify and right-shift mantissa into a Q4.20 magnitude.
  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.sign  = s1_q.sign;
    sh_diff    = EXP_WIDTH'(EXP_SAT) - s1_q.exp;
    shamt      = (sh_diff > EXP_WIDTH'(MAX_SHIFT)) ? SHAMT_WIDTH'(MAX_SHIFT)
                                                   : sh_diff[SHAMT_WIDTH-1:0];
`ifdef ROUND_NEAREST_EN
    {mag_trunc, rem} = {s1_q.mant, MANT_WIDTH'(0)} >> shamt;
    round_up         = rem[MANT_WIDTH-1] & ((|rem[MANT_WIDTH-2:0]) | mag_trunc[0]);
    s2_d.mag         = {1'b0, mag_trunc} + MAG_WIDTH'(round_up);
`else
    mag_trunc        = s1_q.mant >> shamt;
    s2_d.mag         = {1'b0, mag_trunc};
`endif
    if (s1_q.exp == '0 || (s1_q.exp == '1 && s1_q.frac_nz)) begin
      s2_d.mag = '0;
    end else if (s1_q.exp >= EXP_WIDTH'(EXP_SAT)) begin
      s2_d.sat = 1'b1;
    end
  end

  // Stage 3: apply sign, saturating out-of-range (or round-overflowed) magnitudes.
  always_comb begin
    angle_d = '0;
    if (s2_q.sat || (s2_q.mag > {1'b0, FIXED_MAX})) begin
      angle_d = s2_q.sign ? FIXED_MIN : FIXED_MAX;
    end else if (s2_q.sign) begin
      angle_d = fixed_t'(~s2_q.mag[CORDIC_DATA_WIDTH-1:0] + CORDIC_DATA_WIDTH'(1));
    end else begin
      angle_d = fixed_t'(s2_q.mag[CORDIC_DATA_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
    end else if (clk_en) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      angle       <= angle_d;
      angle_valid <= s2_q.valid;
    end
  end

  // Both operands are fixed_t, so these compare as two's complement.
  assign agb = (angle > working_angle);
  assign aeb = (angle == working_angle);

  delay_counter u_delay_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (delay_clr),
    .max  (counter_max),
    .done (counter_done)
  );

endmodule

// File: tb/tb_fp_fixed_convert_cmp.sv
// Self-checking bench for fp_fixed_convert_cmp: directed tables, corner sequences, random model check.
module tb_fp_fixed_convert_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] angle_float;
  logic [23:0] angle;
  logic        angle_valid;
  logic [23:0] working_angle;
  logic        agb;
  logic        aeb;
  logic [9:0]  counter_max;
  logic        delay_clr;
  logic        counter_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp_fixed_convert_cmp dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .angle_float   (angle_float),
    .angle         (angle),
    .angle_valid   (angle_valid),
    .working_angle (working_angle),
    .agb           (agb),
    .aeb           (aeb),
    .counter_max   (counter_max),
    .delay_clr     (delay_clr),
    .counter_done  (counter_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value-level model: |v| * 2^20 computed in reals, then truncated (or rounded) and saturated.
  function automatic logic [23:0] ref_conv(input logic [31:0] f);
    int  e;
    int  t;
    real scaled;
    real fl;
    e = int'(f[30:23]);
    if (e == 0) return 24'h0;
    if (e == 255) return (f[22:0] != 23'h0) ? 24'h0 : (f[31] ? 24'h800000 : 24'h7FFFFF);
    scaled = (8388608.0 + real'(f[22:0])) * (2.0 ** real'(e - 130));
    if (scaled >= 8388608.0) return f[31] ? 24'h800000 : 24'h7FFFFF;
    fl = $floor(scaled);
`ifdef ROUND_NEAREST_EN
    if ((scaled - fl) > 0.5 || ((scaled - fl) == 0.5 && ($rtoi(fl) % 2) == 1)) fl = fl + 1.0;
`endif
    t = $rtoi(fl);
    if (t > 8388607) return f[31] ? 24'h800000 : 24'h7FFFFF;
    return f[31] ? 24'(-t) : 24'(t);
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] specials [8];
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'hC1000000, 32'h40FFFFFF, 32'h00400000};
    case ($urandom_range(0, 5))
      0:       return $urandom;
      4:       return specials[$urandom_range(0, 7)];
      5:       return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)), 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(104, 131)), 23'($urandom)};
    endcase
  endfunction

  typedef struct {
    logic [31:0] f;
    logic [23:0] want;
    string       name;
  } conv_vec_t;

  typedef struct {
    logic [23:0] wa;
    logic        agb;
    logic        aeb;
  } cmp_vec_t;

`ifdef ROUND_NEAREST_EN
  localparam logic [23:0] PI4_WANT = 24'h0C90FE;
`else
  localparam logic [23:0] PI4_WANT = 24'h0C90FD;
`endif

  conv_vec_t   cv [12];
  cmp_vec_t    mv [6];
  logic [23:0] q [$];
  logic [23:0] exp_angle;
  logic        exp_valid;
  logic        en;
  int          cnt;

  initial begin
    cv[0]  = '{32'h3F800000, 24'h100000, "one"};
    cv[1]  = '{32'hBF800000, 24'hF00000, "minus_one"};
    cv[2]  = '{32'h3F490FDB, PI4_WANT,   "pi_over_4"};
    cv[3]  = '{32'h41200000, 24'h7FFFFF, "ten_sat"};
    cv[4]  = '{32'hC1000000, 24'h800000, "minus_eight"};
    cv[5]  = '{32'h00000000, 24'h000000, "zero"};
    cv[6]  = '{32'h7FC00000, 24'h000000, "nan"};
    cv[7]  = '{32'h80000000, 24'h000000, "neg_zero"};
    cv[8]  = '{32'hFF800000, 24'h800000, "neg_inf"};
    cv[9]  = '{32'hC0200000, 24'hD80000, "minus_2p5"};
    cv[10] = '{32'h40FFFFFF, 24'h7FFFFF, "just_below_8"};
    cv[11] = '{32'h34800000, 24'h000000, "tiny"};

    mv[0] = '{24'h0FFFFF, 1'b1, 1'b0};
    mv[1] = '{24'h100000, 1'b0, 1'b1};
    mv[2] = '{24'hF00000, 1'b1, 1'b0};
    mv[3] = '{24'h100001, 1'b0, 1'b0};
    mv[4] = '{24'h7FFFFF, 1'b0, 1'b0};
    mv[5] = '{24'h800000, 1'b1, 1'b0};

    rst = 1'b0; clk_en = 1'b0; angle_float = '0; working_angle = '0;
    counter_max = 10'd5; delay_clr = 1'b0;
    repeat (2) tick();
    chk("reset_angle", 32'(angle), 32'h0);
    chk("reset_valid", 32'(angle_valid), 32'h0);
    chk("reset_done", 32'(counter_done), 32'h0);
    rst = 1'b1;

    // Latency: sample captured on edge 1 appears on edge 3.
    angle_float = 32'h3F800000; clk_en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("latency_valid", 32'(angle_valid), (e == 3) ? 32'h1 : 32'h0);
      chk("latency_angle", 32'(angle), (e == 3) ? 32'h100000 : 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      angle_float = cv[i].f;
      repeat (3) tick();
      chk(cv[i].name, 32'(angle), 32'(cv[i].want));
    end

    angle_float = 32'h3F800000;
    repeat (3) tick();
    clk_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      working_angle = mv[i].wa;
      #1;
      chk("cmp_agb", 32'(agb), 32'(mv[i].agb));
      chk("cmp_aeb", 32'(aeb), 32'(mv[i].aeb));
    end

    // Stall two cycles between capture and the remaining stages.
    rst = 1'b0; #1; rst = 1'b1;
    clk_en = 1'b1; angle_float = 32'h3F800000;
    tick();
    clk_en = 1'b0; angle_float = 32'h40000000;
    repeat (2) begin
      tick();
      chk("stall_valid_low", 32'(angle_valid), 32'h0);
    end
    clk_en = 1'b1;
    tick();
    chk("stall_valid_low", 32'(angle_valid), 32'h0);
    tick();
    chk("stall_valid", 32'(angle_valid), 32'h1);
    chk("stall_angle", 32'(angle), 32'h100000);
    clk_en = 1'b0;
    repeat (2) begin
      tick();
      chk("hold_angle", 32'(angle), 32'h100000);
      chk("hold_valid", 32'(angle_valid), 32'h1);
    end
    clk_en = 1'b1;
    tick();
    chk("after_stall_angle", 32'(angle), 32'h200000);

    // Asynchronous reset mid-flight, then a clean refill.
    rst = 1'b0;
    #1;
    chk("async_rst_angle", 32'(angle), 32'h0);
    chk("async_rst_valid", 32'(angle_valid), 32'h0);
    chk("async_rst_done", 32'(counter_done), 32'h0);
    rst = 1'b1; angle_float = 32'h3F000000;
    repeat (2) tick();
    chk("refill_valid_low", 32'(angle_valid), 32'h0);
    tick();
    chk("refill_valid", 32'(angle_valid), 32'h1);
    chk("refill_angle", 32'(angle), 32'h080000);

    // Delay counter: runs independent of clk_en.
    clk_en = 1'b0; counter_max = 10'd5; delay_clr = 1'b1;
    tick();
    chk("cnt_clr_done", 32'(counter_done), 32'h0);
    delay_clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("cnt5_done", 32'(counter_done), (k >= 5) ? 32'h1 : 32'h0);
    end
    counter_max = 10'd0; delay_clr = 1'b1;
    tick();
    delay_clr = 1'b0;
    chk("cnt0_done", 32'(counter_done), 32'h1);
    counter_max = 10'd20; delay_clr = 1'b1;
    tick();
    delay_clr = 1'b0;
    repeat (10) tick();
    chk("cnt20_running", 32'(counter_done), 32'h0);
    counter_max = 10'd3;
    #1;
    chk("cnt_lowered_done", 32'(counter_done), 32'h1);
    repeat (3) tick();
    chk("cnt_lowered_hold", 32'(counter_done), 32'h1);
    counter_max = 10'd12;
    #1;
    chk("cnt_raised_done", 32'(counter_done), 32'h0);
    repeat (2) tick();
    chk("cnt_raised_reach", 32'(counter_done), 32'h1);

    // Randomized traffic against the value-level model.
    rst = 1'b0; #1; rst = 1'b1;
    q.delete(); exp_angle = '0; exp_valid = 1'b0; cnt = 0;
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      clk_en      = en;
      angle_float = rand_float();
      delay_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) counter_max = 10'($urandom_range(0, 20));
      tick();
      if (en) begin
        q.push_back(ref_conv(angle_float));
        if (q.size() == 3) begin
          exp_angle = q.pop_front();
          exp_valid = 1'b1;
        end
      end
      if (delay_clr) cnt = 0;
      else if (cnt < int'(counter_max)) cnt++;
      chk("rand_angle", 32'(angle), 32'(exp_angle));
      chk("rand_valid", 32'(angle_valid), 32'(exp_valid));
      chk("rand_done", 32'(counter_done), (cnt >= int'(counter_max)) ? 32'h1 : 32'h0);
      case ($urandom_range(0, 3))
        0:       working_angle = exp_angle;
        1:       working_angle = exp_angle + 24'd1;
        2:       working_angle = exp_angle - 24'd1;
        default: working_angle = 24'($urandom);
      endcase
      #1;
      chk("rand_agb", 32'(agb), ($signed(exp_angle) > $signed(working_angle)) ? 32'h1 : 32'h0);
      chk("rand_aeb", 32'(aeb), (exp_angle == working_angle) ? 32'h1 : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
